// File: rtl/mdu_pkg.sv
// mdu_pkg: MDUOp encodings, FSM state codes and op-decode helpers.
// MADD/MADDU are only accepted when MDU_MADD_EN is defined.
package mdu_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'b0000,
    OP_MULT  = 4'b0001,
    OP_MULTU = 4'b0010,
    OP_DIV   = 4'b0011,
    OP_DIVU  = 4'b0100,
    OP_MTHI  = 4'b0101,
    OP_MTLO  = 4'b0110,
    OP_MADD  = 4'b1000,
    OP_MADDU = 4'b1001
  } op_t;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  function automatic logic is_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU};
`else
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: execute-stage operand/request bus and HI/LO/Busy results of the MDU.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  modport master (output A, B, MDUOp, Start, input HI, LO, Busy);
  modport slave (input A, B, MDUOp, Start, output HI, LO, Busy);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: IDLE/BUSY sequencer with latency down-counter; pulses done on the completing cycle.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic div,
  output logic busy,
  output logic done
);
  localparam int NMAX = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = NMAX > 1 ? $clog2(NMAX) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done    = 1'b0;
    if (state == IDLE) begin
      if (go) begin
        state_n = BUSY;
        cnt_n   = div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      end
    end else if (cnt == '0) begin
      done    = 1'b1;
      state_n = IDLE;
    end else begin
      cnt_n = cnt - 1'b1;
    end
  end
  assign busy = state == BUSY;
endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI/LO; operands latched at acceptance.
// Optional MADD/MADDU accumulate ops enabled by defining MDU_MADD_EN.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);
  logic [31:0] a_r, b_r, hi, lo, ua, ub, uq, ur, quo, rem;
  logic [3:0]  op_r;
  logic [63:0] prod, acc;
  logic        accept, done, busy, sgn, na, nb;
  assign accept = bus.Start & ~busy & is_long(bus.MDUOp);
  mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_ctrl (
    .clk  (clk),
    .reset(reset),
    .go   (accept),
    .div  (is_div(bus.MDUOp)),
    .busy (busy),
    .done (done)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_r  <= '0;
      b_r  <= '0;
      op_r <= OP_NONE;
    end else if (accept) begin
      a_r  <= bus.A;
      b_r  <= bus.B;
      op_r <= bus.MDUOp;
    end
  assign sgn  = op_r inside {OP_MULT, OP_DIV, OP_MADD};
  assign na   = sgn & a_r[31];
  assign nb   = sgn & b_r[31];
  assign prod = {{32{na}}, a_r} * {{32{nb}}, b_r};
  // Signed divide via magnitudes; INT_MIN/-1 naturally wraps to INT_MIN rem 0.
  assign ua  = na ? -a_r : a_r;
  assign ub  = nb ? -b_r : b_r;
  assign uq  = ub == '0 ? '0 : ua / ub;
  assign ur  = ub == '0 ? '0 : ua % ub;
  assign quo = (na ^ nb) ? -uq : uq;
  assign rem = na ? -ur : ur;
`ifdef MDU_MADD_EN
  assign acc = op_r inside {OP_MADD, OP_MADDU} ? {hi, lo} + prod : prod;
`else
  assign acc = prod;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      if (!is_div(op_r)) {hi, lo} <= acc;
      else if (b_r != '0) {hi, lo} <= {rem, quo};
    end else if (bus.Start && !busy) begin
      if (bus.MDUOp == OP_MTHI) hi <= bus.A;
      if (bus.MDUOp == OP_MTLO) lo <= bus.A;
    end
  assign bus.HI   = hi;
  assign bus.LO   = lo;
  assign bus.Busy = busy;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu; expected HI/LO queued at issue, checked when Busy drops.
module tb_mdu;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  mdu_if bus ();
  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] hilo;
    int          n;
    string       tag;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.MDUOp = op;
    bus.A = a;
    bus.B = b;
    tick();
    bus.Start = 1'b0;
    bus.MDUOp = OP_NONE;
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [63:0] r;
    sa = a;
    sb = b;
    r = {m_hi, m_lo};
    case (op)
      OP_MULT:  r = 64'(longint'(sa) * longint'(sb));
      OP_MULTU: r = {32'b0, a} * {32'b0, b};
      OP_DIV:
        if (b == 0) r = {m_hi, m_lo};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b != 0) r = {a % b, a / b};
      OP_MADD:  r = {m_hi, m_lo} + 64'(longint'(sa) * longint'(sb));
      OP_MADDU: r = {m_hi, m_lo} + {32'b0, a} * {32'b0, b};
      default:  r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  task automatic wait_done(input int pre);
    int cnt;
    exp_t e;
    cnt = pre;
    while (bus.Busy && cnt < 200) begin
      cnt++;
      tick();
    end
    e = sb.pop_front();
    check({e.tag, "_busy_cycles"}, 64'(cnt), 64'(e.n));
    check({e.tag, "_hilo"}, {bus.HI, bus.LO}, e.hilo);
    m_hi = e.hilo[63:32];
    m_lo = e.hilo[31:0];
  endtask

  task automatic long_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    sb.push_back('{exp, is_div(op) ? 10 : 5, tag});
    drive(op, a, b);
    wait_done(0);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    drive(op, a, 32'h0);
    if (op == OP_MTHI) m_hi = a;
    else m_lo = a;
    check("mt_busy", 64'(bus.Busy), 64'(0));
    check("mt_hilo", {bus.HI, bus.LO}, {m_hi, m_lo});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rop;
    logic [31:0] ra, rb;
    bus.Start = 1'b0;
    bus.MDUOp = OP_NONE;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.Busy), 64'(0));
    check("reset_hilo", {bus.HI, bus.LO}, 64'h0);
    reset = 1'b1;
    tick();

    long_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    long_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    long_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    long_op("divu", OP_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
    long_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    long_op("div_rem", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);

    mt(OP_MTHI, 32'h1234_5678);
    long_op("div_zero", OP_DIV, 32'd99, 32'd0, {32'h1234_5678, m_lo});

    // Requests issued while busy must be dropped.
    sb.push_back('{64'h0000_0000_0000_0015, 5, "mult_ign"});
    drive(OP_MULT, 32'd3, 32'd7);
    drive(OP_DIV, 32'd100, 32'd3);
    drive(OP_MTLO, 32'h0000_AAAA, 32'd0);
    wait_done(2);
    check("ign_idle_after", 64'(bus.Busy), 64'(0));

    drive(OP_NONE, 32'hDEAD_BEEF, 32'd1);
    check("none_noeffect", {bus.Busy, bus.HI, bus.LO}, {1'b0, m_hi, m_lo});

    drive(OP_MULT, 32'd3, 32'd5);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 64'(bus.Busy), 64'(0));
    check("rst_hilo", {bus.HI, bus.LO}, 64'h0);
    m_hi = '0;
    m_lo = '0;
    #1 reset = 1'b1;
    repeat (7) tick();
    check("rst_nowrite", {bus.Busy, bus.HI, bus.LO}, 65'h0);
    long_op("post_rst", OP_MULTU, 32'd6, 32'd7, 64'd42);

    mt(OP_MTHI, 32'h0);
    mt(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    sb.push_back('{64'h0000_0001_0000_0000, 5, "maddu"});
    drive(OP_MADDU, 32'd1, 32'd1);
    wait_done(0);
    sb.push_back('{model(OP_MADD, 32'hFFFF_FFFF, 32'd3), 5, "madd"});
    drive(OP_MADD, 32'hFFFF_FFFF, 32'd3);
    wait_done(0);
`else
    drive(OP_MADDU, 32'd1, 32'd1);
    check("maddu_off", {bus.Busy, bus.HI, bus.LO}, {1'b0, 32'h0, 32'hFFFF_FFFF});
`endif

    for (int i = 0; i < 8; i++) begin
      rop = 4'(i % 4 + 1);
      ra = $urandom;
      rb = is_div(rop) ? ($urandom >> (i * 3)) : $urandom;
      sb.push_back('{model(rop, ra, rb), is_div(rop) ? 10 : 5, $sformatf("rand%0d", i)});
      drive(rop, ra, rb);
      wait_done(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
